seq_divider: RTL
================

Name: seq_divider

Overview:
- Parametrised multi-cycle shift-subtract (restoring) divider.
- Controller/datapath block driven by start and reporting ready, as in the existing arithmetic devices.
- Generalises the fixed 16-bit/8-bit iterative unit: widths are parameters, and it adds a remainder output, divide-by-zero detection and a done pulse.
- Sits between the operand registers and the result bus of the arithmetic subsystem.

Parameters:
- XW, 16, dividend and quotient width (bits), >= 2
- YW, 8, divisor and remainder width (bits), 2 <= YW <= XW
- CW, $clog2(XW+1), iteration counter width (derived, not overridden)

Ports:
- clk  in  1  system clock; all flops rising-edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only while ready=1
- mode  in  1  1 = signed operands (only with SIGNED_EN, otherwise ignored)
- xin  in  XW  dividend
- yin  in  YW  divisor
- out  out  XW  quotient, registered
- rem  out  YW  remainder, registered
- dz  out  1  divide-by-zero flag for the current result
- done  out  1  one-cycle pulse when out/rem/dz become valid
- ready  out  1  high when idle and able to accept start

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, out=0, rem=0, dz=0, done=0, ready=1, counter=0.
  - Takes effect mid-operation; the operation in progress is discarded with no done pulse.
- States: IDLE, DIV, DONE.
- IDLE:
  - ready=1.
  - On an edge with start=1: latch xin/yin (and mode).
  - If yin==0, go to DONE and set dz=1, out = all ones, rem = xin[YW-1:0].
  - Otherwise go to DIV with: partial remainder P=0 (YW+1 bits), shift register Q=|xin|, counter=0, ready=0.
- DIV, one quotient bit per edge:
  - {P,Q} shifted left by 1.
  - If P >= |yin|, then P = P - |yin| and Q[0]=1; otherwise Q[0]=0.
  - counter increments each edge.
  - After the XW-th DIV edge, go to DONE with out=Q and rem=P[YW-1:0], sign-corrected in signed mode.
- DONE:
  - Lasts exactly one cycle with done=1 and ready=1.
  - Returns to IDLE at the next edge.
  - A start seen in DONE is accepted exactly as in IDLE, so back-to-back operation is allowed.
- Latency:
  - Normal division: done rises XW+1 edges after the start edge (17 for XW=16).
  - Divide by zero: done rises 1 edge after the start edge.
- Handshake:
  - start while ready=0 is ignored, and xin/yin may change freely during DIV.
  - out/rem/dz hold their values until the next accepted operation completes.
  - dz clears at the completion of the next non-zero division.
- Widths:
  - Internal P is YW+1 bits so the compare cannot overflow.
  - The quotient is exact for all unsigned inputs and fits in XW bits.

Optional Feature:
- Macro SIGNED_EN.
- Defined:
  - mode=1 treats xin/yin as two's complement.
  - Magnitudes are divided unsigned.
  - The quotient is negated if the operand signs differ, truncating toward zero.
  - rem takes the sign of the dividend.
  - Overflow case (most-negative xin / -1) wraps to out = 1 followed by XW-1 zeros, dz=0.
  - Divide by zero in signed mode gives the same flags and values as unsigned.
- Undefined:
  - mode is ignored; all operations are unsigned.
  - The sign-correction logic is absent.

Test Plan:
- Unsigned divide, XW=16/YW=8: xin=1000, yin=7, start pulsed one cycle → done after 17 edges; out=142, rem=6, dz=0; ready=0 during DIV, then 1.
- Extremes: xin=0xFFFF, yin=0xFF → out=257, rem=0; xin=0xFFFF, yin=1 → out=0xFFFF, rem=0.
- Divide by zero: xin=0x1234, yin=0 → done 1 edge later; dz=1, out=0xFFFF, rem=0x34; a following 10/3 → out=3, rem=1, dz=0.
- Handshake and reset:
  - start pulsed at DIV edge 5 with new operands → ignored; the original result is unchanged.
  - rst asserted at DIV edge 8 → out=0, ready=1 immediately and no done pulse.
  - Back-to-back: start asserted during the DONE cycle is accepted.
- SIGNED_EN:
  - mode=1, xin=-100 (0xFF9C), yin=7 → out=0xFFF2 (-14), rem=0xFE (-2).
  - xin=0x8000, yin=0xFF → out=0x8000, dz=0.
  - mode=0 with the same first operands → out=9348, rem=0.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring shift-subtract divider.
// Produces one quotient bit per clock; start is accepted while ready=1
// (idle or the single done cycle, so back-to-back operation works).
// Optional macro SIGNED_EN: adds two's complement support selected by mode.
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-low reset
//   start - operation request, sampled while ready=1
//   mode  - 1 = signed operands (SIGNED_EN only, otherwise ignored)
//   xin   - dividend (XW bits)
//   yin   - divisor (YW bits)
//   out   - quotient, registered
//   rem   - remainder, registered
//   dz    - divide-by-zero flag for the current result
//   done  - one-cycle pulse when out/rem/dz become valid
//   ready - high when able to accept start
module seq_divider #(
  parameter int unsigned XW = 16,
  parameter int unsigned YW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [XW-1:0] xin,
  input  logic [YW-1:0] yin,
  output logic [XW-1:0] out,
  output logic [YW-1:0] rem,
  output logic          dz,
  output logic          done,
  output logic          ready
);

  localparam int unsigned CW = $clog2(XW + 1);
  localparam logic [CW-1:0] LAST = CW'(XW - 1);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Partial remainder is always below the divisor between steps, so YW bits
  // suffice for storage; the shifted value uses YW+1 bits for the compare.
  logic [YW-1:0] p_q, p_d;
  logic [XW-1:0] q_q, q_d;
  logic [YW-1:0] y_q, y_d;
  logic [XW-1:0] out_d;
  logic [YW-1:0] rem_d;
  logic          dz_d, done_d, ready_d;
  logic [YW:0]   p_sh;
  logic [XW-1:0] q_sh;
  logic [XW-1:0] xmag;
  logic [YW-1:0] ymag;

`ifdef SIGNED_EN
  // Sign of quotient and of remainder, captured at start.
  logic sq_q, sq_d, sr_q, sr_d;
  logic sx, sy;
  assign sx   = mode & xin[XW-1];
  assign sy   = mode & yin[YW-1];
  assign xmag = sx ? (~xin + XW'(1)) : xin;
  assign ymag = sy ? (~yin + YW'(1)) : yin;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign xmag = xin;
  assign ymag = yin;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    q_d     = q_q;
    y_d     = y_q;
    out_d   = out;
    rem_d   = rem;
    dz_d    = dz;
    done_d  = 1'b0;
    ready_d = ready;
    p_sh    = {p_q, q_q[XW-1]};
    q_sh    = {q_q[XW-2:0], 1'b0};
`ifdef SIGNED_EN
    sq_d    = sq_q;
    sr_d    = sr_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
        if (start) begin
          if (yin == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            dz_d    = 1'b1;
            out_d   = '1;
            rem_d   = xin[YW-1:0];
          end else begin
            state_d = DIV;
            ready_d = 1'b0;
            cnt_d   = '0;
            p_d     = '0;
            q_d     = xmag;
            y_d     = ymag;
`ifdef SIGNED_EN
            sq_d    = sx ^ sy;
            sr_d    = sx;
`endif
          end
        end
      end
      DIV: begin
        if (p_sh >= {1'b0, y_q}) begin
          p_d = YW'(p_sh - {1'b0, y_q});
          q_d = q_sh | XW'(1);
        end else begin
          p_d = p_sh[YW-1:0];
          q_d = q_sh;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          ready_d = 1'b1;
          dz_d    = 1'b0;
`ifdef SIGNED_EN
          out_d   = sq_q ? (~q_d + XW'(1)) : q_d;
          rem_d   = sr_q ? (~p_d + YW'(1)) : p_d;
`else
          out_d   = q_d;
          rem_d   = p_d;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      y_q     <= '0;
      out     <= '0;
      rem     <= '0;
      dz      <= 1'b0;
      done    <= 1'b0;
      ready   <= 1'b1;
`ifdef SIGNED_EN
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      y_q     <= y_d;
      out     <= out_d;
      rem     <= rem_d;
      dz      <= dz_d;
      done    <= done_d;
      ready   <= ready_d;
`ifdef SIGNED_EN
      sq_q    <= sq_d;
      sr_q    <= sr_d;
`endif
    end
  end

endmodule
